// File: rtl/pow5_arb_sched.sv
// Arbiter and response router for N requesters sharing one fixed-latency pow-5 pipe.
// Define POW5_ARB_ROUND_ROBIN_EN for round-robin grants; default is fixed priority.
module pow5_arb_sched #(
    parameter int n_req   = 4,
    parameter int w       = 8,
    parameter int latency = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [n_req-1:0]   req_vld,
    input  logic [n_req*w-1:0] req_data,
    output logic [n_req-1:0]   req_rdy,
    output logic               pipe_vld,
    output logic [w-1:0]       pipe_data,
    input  logic               res_vld,
    input  logic [w-1:0]       res_data,
    output logic [n_req-1:0]   rsp_vld,
    output logic [w-1:0]       rsp_data,
    output logic               err
);

    localparam int PW = (n_req > 1) ? $clog2(n_req) : 1;
    localparam int D  = latency + 1;

    logic [PW-1:0] w_ptr;
    logic [PW-1:0] w_idx;
    logic          w_hs;
    logic [w-1:0]  w_sel;
    logic          w_old_v;

    logic          r_pipe_vld;
    logic [w-1:0]  r_pipe_data;
    logic [D-1:0]  r_tv;
    logic [PW-1:0] r_tag [D];
    logic          r_err;

    // Circular search from the pointer; first valid requester wins.
    always_comb begin : p_grant
        int j;
        req_rdy = '0;
        w_idx   = '0;
        w_hs    = 1'b0;
        w_sel   = '0;
        j       = 0;
        if (!rst) begin
            for (int k = 0; k < n_req; k++) begin
                j = (int'(w_ptr) + k) % n_req;
                if (!w_hs && req_vld[j]) begin
                    w_hs       = 1'b1;
                    req_rdy[j] = 1'b1;
                    w_idx      = PW'(j);
                    w_sel      = req_data[j*w +: w];
                end
            end
        end
    end

`ifdef POW5_ARB_ROUND_ROBIN_EN
    logic [PW-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_hs) begin
            if (int'(w_idx) == n_req - 1) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_idx + 1'b1;
            end
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld <= 1'b0;
        end else begin
            r_pipe_vld <= w_hs;
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_pipe_data <= w_sel;
        end
    end

    assign pipe_vld  = r_pipe_vld;
    assign pipe_data = r_pipe_data;

    // Stage 0 aligns with pipe_vld; stage D-1 aligns with res_vld.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tv <= '0;
        end else begin
            r_tv <= {r_tv[D-2:0], w_hs};
        end
    end

    always_ff @(posedge clk) begin
        r_tag[0] <= w_idx;
        for (int k = 1; k < D; k++) begin
            r_tag[k] <= r_tag[k-1];
        end
    end

    assign w_old_v = r_tv[D-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (res_vld != w_old_v) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

    always_comb begin
        rsp_vld = '0;
        if (!rst && res_vld && w_old_v) begin
            rsp_vld[r_tag[D-1]] = 1'b1;
        end
    end

    assign rsp_data = res_data;

endmodule

// File: tb/tb_pow5_arb_sched.sv
// Bench for pow5_arb_sched: directed stimulus, queue-based reference model, literal checks.
module tb_pow5_arb_sched;

    localparam int N = 4;
    localparam int W = 16;
    localparam int L = 4;
`ifdef POW5_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_vld = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_rdy;
    logic           pipe_vld;
    logic [W-1:0]   pipe_data;
    logic           res_vld;
    logic [W-1:0]   res_data;
    logic [N-1:0]   rsp_vld;
    logic [W-1:0]   rsp_data;
    logic           err;
    logic           inj = 1'b0;
    logic [W-1:0]   inj_data = '0;

    int n_chk  = 0;
    int n_fail = 0;

    pow5_arb_sched #(.n_req(N), .w(W), .latency(L)) dut (
        .clk(clk),
        .rst(rst),
        .req_vld(req_vld),
        .req_data(req_data),
        .req_rdy(req_rdy),
        .pipe_vld(pipe_vld),
        .pipe_data(pipe_data),
        .res_vld(res_vld),
        .res_data(res_data),
        .rsp_vld(rsp_vld),
        .rsp_data(rsp_data),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pow5(input logic [W-1:0] x);
        logic [W-1:0] r;
        r = x;
        for (int k = 0; k < 4; k++) r = r * x;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Shared datapath stand-in: fixed latency L from pipe_vld to res_vld.
    logic [L-1:0] dp_v;
    logic [W-1:0] dp_d [L];

    always @(posedge clk) begin
        if (rst) begin
            dp_v <= '0;
        end else begin
            dp_v <= {dp_v[L-2:0], pipe_vld};
        end
        dp_d[0] <= pipe_data;
        for (int k = 1; k < L; k++) dp_d[k] <= dp_d[k-1];
    end

    assign res_vld  = dp_v[L-1] | inj;
    assign res_data = inj ? inj_data : pow5(dp_d[L-1]);

    // Reference model: issue queue keyed by the cycle each response is due.
    typedef struct {
        int           due;
        int           idx;
        logic [W-1:0] d;
    } ent_t;

    ent_t         q[$];
    int           cyc   = 0;
    int           mptr  = 0;
    bit           e_pv  = 1'b0;
    logic [W-1:0] e_pd  = '0;
    bit           e_err = 1'b0;
    int           m_g;
    bit           m_due;
    logic [N-1:0] m_rdy;
    logic [N-1:0] m_rsp;

    always @(negedge clk) begin
        m_rdy = '0;
        m_g   = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                if (m_g < 0 && req_vld[(mptr + k) % N]) m_g = (mptr + k) % N;
            end
        end
        if (m_g >= 0) m_rdy[m_g] = 1'b1;
        m_due = (q.size() > 0) && (q[0].due == cyc);
        m_rsp = '0;
        if (!rst && res_vld && m_due) m_rsp[q[0].idx] = 1'b1;

        chk("m_rdy", req_rdy, m_rdy);
        chk("m_pipe_vld", pipe_vld, e_pv);
        if (e_pv) chk("m_pipe_data", pipe_data, e_pd);
        chk("m_rsp_vld", rsp_vld, m_rsp);
        if (m_rsp != '0) chk("m_rsp_data", rsp_data, pow5(q[0].d));
        chk("m_err", err, e_err);

        if (rst) begin
            q.delete();
            mptr  = 0;
            e_pv  = 1'b0;
            e_err = 1'b0;
        end else begin
            e_err = e_err | (res_vld != m_due);
            if (m_due) void'(q.pop_front());
            e_pv = (m_g >= 0);
            if (m_g >= 0) begin
                e_pd = req_data[m_g*W +: W];
                q.push_back('{due: cyc + 1 + L, idx: m_g, d: e_pd});
                if (RR) mptr = (m_g + 1) % N;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [N-1:0] g [8];
    logic [N-1:0] pats [7] = '{4'b1010, 4'b0110, 4'b1001, 4'b0000,
                               4'b1111, 4'b0001, 4'b1100};

    initial begin
        req_vld = 4'b1111;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(i + 1);
        @(negedge clk);
        chk("rst_rdy", req_rdy, 4'b0000);
        chk("rst_rsp", rsp_vld, 4'b0000);
        step();
        step();
        rst     = 1'b0;
        req_vld = '0;
        @(negedge clk);
        chk("rst_err", err, 1'b0);
        chk("rst_pipe_vld", pipe_vld, 1'b0);

        // Single issue from requester 2, operand 3.
        step();
        req_vld = 4'b0100;
        req_data[2*W +: W] = 16'd3;
        @(negedge clk);
        chk("t1_rdy", req_rdy, 4'b0100);
        step();
        req_vld = '0;
        @(negedge clk);
        chk("t1_pipe_vld", pipe_vld, 1'b1);
        chk("t1_pipe_data", pipe_data, 16'd3);
        repeat (4) step();
        @(negedge clk);
        chk("t1_rsp_vld", rsp_vld, 4'b0100);
        chk("t1_rsp_data", rsp_data, 16'd243);

        // All requesters held for eight cycles.
        do_reset();
        step();
        req_vld = 4'b1111;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(i + 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            g[k] = req_rdy;
            step();
        end
        req_vld = '0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t2_grant%0d", k), g[k],
                RR ? (4'b0001 << (k % 4)) : 4'b0001);
        end
        repeat (L + 3) step();

        // Back-to-back issues from requesters 1 and 3.
        do_reset();
        step();
        req_vld = 4'b0010;
        req_data[1*W +: W] = 16'd2;
        @(negedge clk);
        chk("t3_rdy1", req_rdy, 4'b0010);
        step();
        req_vld = 4'b1000;
        req_data[3*W +: W] = 16'd4;
        @(negedge clk);
        chk("t3_rdy3", req_rdy, 4'b1000);
        step();
        req_vld = '0;
        repeat (3) step();
        @(negedge clk);
        chk("t3_rsp_a", rsp_vld, 4'b0010);
        chk("t3_dat_a", rsp_data, 16'd32);
        step();
        @(negedge clk);
        chk("t3_rsp_b", rsp_vld, 4'b1000);
        chk("t3_dat_b", rsp_data, 16'd1024);

        // Mixed request patterns, checked by the model.
        for (int k = 0; k < 7; k++) begin
            step();
            req_vld = pats[k];
            for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(k * 3 + i + 2);
        end
        step();
        req_vld = '0;
        repeat (L + 3) step();

        // Reset two cycles after an issue drops the response.
        step();
        req_vld = 4'b0010;
        req_data[1*W +: W] = 16'd5;
        step();
        req_vld = '0;
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < L + 2; k++) begin
            @(negedge clk);
            chk("t5_rsp_none", rsp_vld, 4'b0000);
            chk("t5_err", err, 1'b0);
            step();
        end
        req_vld = 4'b1111;
        @(negedge clk);
        chk("t5_first_grant", req_rdy, 4'b0001);
        step();
        req_vld = '0;
        repeat (L + 3) step();

        // Unexpected result sets the sticky error.
        inj      = 1'b1;
        inj_data = 16'h0007;
        @(negedge clk);
        chk("t4_inj_rsp", rsp_vld, 4'b0000);
        step();
        inj = 1'b0;
        @(negedge clk);
        chk("t4_err_set", err, 1'b1);
        repeat (3) step();
        @(negedge clk);
        chk("t4_err_hold", err, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t4_err_clr", err, 1'b0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pow5_arb_sched.md
POW5_ARB_SCHED -- requirements
Module: pow5_arb_sched

Interface
REQ-001 SHALL have parameter n_req, default 4, number of requesters sharing one fixed-latency pow-5 datapath.
REQ-002 SHALL have parameter w, default 8, data width of operands and results.
REQ-003 SHALL have parameter latency, default 4, cycles from pipe_vld to res_vld of the shared datapath (range 1..16).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port req_vld  input  n_req  per-requester operand valid.
REQ-007 SHALL have port req_data  input  n_req*w  per-requester operand, requester i at bits [i*w +: w].
REQ-008 SHALL have port req_rdy  output  n_req  one-hot grant; handshake on req_vld[i] && req_rdy[i].
REQ-009 SHALL have port pipe_vld  output  1  issue valid to datapath.
REQ-010 SHALL have port pipe_data  output  w  issued operand.
REQ-011 SHALL have port res_vld  input  1  datapath result valid.
REQ-012 SHALL have port res_data  input  w  datapath result.
REQ-013 SHALL have port rsp_vld  output  n_req  one-hot result valid routed to owning requester.
REQ-014 SHALL have port rsp_data  output  w  result data, shared by all requesters.
REQ-015 SHALL have port err  output  1  sticky protocol error flag.

Function
REQ-016 SHALL grant at most one requester per cycle; req_rdy SHALL be combinational from req_vld and the priority pointer, zero when no req_vld is set.
REQ-017 SHALL never assert req_rdy[i] while req_vld[i] is low.
REQ-018 SHALL register the granted operand: pipe_vld/pipe_data one cycle after the handshake; pipe_vld low in cycles following no handshake.
REQ-019 SHALL load pipe_data only on a handshake (clock-enable style), holding its value otherwise.
REQ-020 SHALL track each issue's requester index in a tag shift pipeline of depth latency+1 with its own valid bit per stage.
REQ-021 SHALL assert rsp_vld[tag] combinationally when res_vld is high and the oldest tag stage is valid; rsp_data SHALL equal res_data.
REQ-022 SHALL keep rsp_vld all-zero when res_vld is low.
REQ-023 SHALL set err and hold it until reset when res_vld is high with oldest tag stage invalid, or the oldest tag stage is valid with res_vld low.
REQ-024 SHALL sustain one issue per cycle; total request-to-response latency = latency+1 cycles.
REQ-025 SHALL tolerate requesters dropping req_vld without a handshake; no state change results.
REQ-026 SHALL track pointer width as ceil(log2(n_req)), minimum 1; n_req=1 SHALL grant requester 0 whenever req_vld[0].

Reset
REQ-027 SHALL, on rst high at a clock edge, clear pipe_vld, all tag valid bits, err and the pointer to 0; pipe_data and tag indices need no reset.
REQ-028 SHALL hold req_rdy, rsp_vld all-zero while rst is high, discarding results in flight; requests in flight are lost.

Configuration
REQ-029 SHALL use macro POW5_ARB_ROUND_ROBIN_EN: defined -> round-robin, pointer moves to (granted index + 1) mod n_req after each handshake, search starts at pointer.
REQ-030 SHALL, without POW5_ARB_ROUND_ROBIN_EN, use fixed priority, lowest index wins, pointer constant 0.

Verification
REQ-031 SHALL cover: n_req=4, latency=4, req_vld=0b0100, data 3 -> req_rdy=0b0100 same cycle, pipe_vld/pipe_data=3 next cycle, rsp_vld=0b0100 with rsp_data=243 five cycles after handshake.
REQ-032 SHALL cover: req_vld=0b1111 held 8 cycles, round-robin -> grants 0,1,2,3,0,1,2,3; fixed priority -> grant 0 every cycle.
REQ-033 SHALL cover: back-to-back issues from requesters 1 then 3, data 2 and 4 -> rsp_vld 0b0010 data 32 then 0b1000 data 1024 (w=16) on consecutive cycles.
REQ-034 SHALL cover: res_vld injected with no issue in flight -> err=1 next cycle and stays 1 until rst.
REQ-035 SHALL cover: rst asserted 2 cycles after an issue -> no rsp_vld afterwards, err=0, next grant from requester 0.
